// File: rtl/cic_up32_feeder.sv
// cic_up32_feeder
//   Upstream framing stage for the x32 CIC interpolator. Stereo PCM pairs
//   written by a one-cycle strobe are held in a small register FIFO and sent
//   out as two-beat Avalon-ST packets: left on the SOP beat, right on the EOP
//   beat. The interpolator's in_ready backpressure is absorbed by the FIFO.
//
//   Optional feature: define CIC_UP32_FEEDER_ATT_EN to arithmetic-shift each
//   sample right by att (0-7) at push time. Without it, att is ignored.
//
//   Handshake (readyLatency 0): a beat transfers on a rising edge where
//   out_valid & out_ready are both high. While out_valid is high and
//   out_ready is low, out_data, out_startofpacket and out_endofpacket hold.
//   A pair leaves the FIFO only when its right (EOP) beat transfers.
//
//   The output FSM state is held in `fsm_state` for hierarchical probing.

module cic_up32_feeder #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [WIDTH-1:0]           snd_l,
   input  logic [WIDTH-1:0]           snd_r,
   input  logic                       snd_strobe,
   input  logic [2:0]                 att,
   output logic [WIDTH-1:0]           out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       out_startofpacket,
   output logic                       out_endofpacket,
   output logic [1:0]                 out_error,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow,
   input  logic                       overflow_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEND_L = 2'd1,
      SEND_R = 2'd2
   } state_t;

   state_t fsm_state;
   state_t state_nx;

   // Pair storage, split into left and right halves.
   logic [WIDTH-1:0] mem_l [DEPTH];
   logic [WIDTH-1:0] mem_r [DEPTH];

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_next;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_after;

   logic [WIDTH-1:0] push_l;
   logic [WIDTH-1:0] push_r;
   logic [WIDTH-1:0] data_nx;

   logic             xfer;
   logic             pop;
   logic             full;
   logic             push;
   logic             ovf_event;

`ifdef CIC_UP32_FEEDER_ATT_EN
   // Headroom against CIC gain: sign-preserving shift applied once, at push.
   assign push_l = WIDTH'($signed(snd_l) >>> att);
   assign push_r = WIDTH'($signed(snd_r) >>> att);
`else
   // Samples stored as presented; att is kept only for a stable interface.
   logic att_unused;
   assign att_unused = ^att;
   assign push_l     = snd_l;
   assign push_r     = snd_r;
`endif

   assign xfer      = out_valid & out_ready;
   assign pop       = (fsm_state == SEND_R) & xfer;
   assign full      = (count == CW'(DEPTH));
   // A full FIFO still accepts a pair when the head pair leaves this cycle.
   assign push      = snd_strobe & (~full | pop);
   assign ovf_event = snd_strobe & full & ~pop;
   assign rd_next   = rd_ptr + 1'b1;

   // Occupancy after this cycle's push/pop; decides SEND_R's successor.
   always_comb begin
      count_after = count + CW'(push) - CW'(pop);
   end

   // Pair storage write port; contents need no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_l[wr_ptr] <= push_l;
         mem_r[wr_ptr] <= push_r;
      end
   end

   // Pointers and occupancy count; pointers wrap modulo DEPTH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_next;
         end
         count <= count_after;
      end
   end

   // Sticky overflow flag; a new overflow wins over a same-cycle clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (ovf_event) begin
         overflow <= 1'b1;
      end else if (overflow_clr) begin
         overflow <= 1'b0;
      end
   end

   // Output FSM next state and the beat to register for the next cycle.
   always_comb begin
      state_nx = fsm_state;
      data_nx  = out_data;
      case (fsm_state)
         IDLE: begin
            if (count != '0) begin
               data_nx  = mem_l[rd_ptr];
               state_nx = SEND_L;
            end
         end
         SEND_L: begin
            if (xfer) begin
               data_nx  = mem_r[rd_ptr];
               state_nx = SEND_R;
            end
         end
         SEND_R: begin
            if (xfer) begin
               if (count_after != '0) begin
                  // With one pair held, the only successor is the pair being
                  // pushed right now, which is not yet in storage.
                  data_nx  = (count == CW'(1)) ? push_l : mem_l[rd_next];
                  state_nx = SEND_L;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // FSM state register and registered Avalon-ST source outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm_state         <= IDLE;
         out_valid         <= 1'b0;
         out_data          <= '0;
         out_startofpacket <= 1'b0;
         out_endofpacket   <= 1'b0;
      end else begin
         fsm_state         <= state_nx;
         out_valid         <= (state_nx != IDLE);
         out_data          <= data_nx;
         out_startofpacket <= (state_nx == SEND_L);
         out_endofpacket   <= (state_nx == SEND_R);
      end
   end

   assign level     = count;
   assign out_error = 2'b00;

endmodule

// File: tb/tb_cic_up32_feeder.sv
// tb_cic_up32_feeder
//   Self-checking bench for cic_up32_feeder. A behavioural model keeps the
//   expected beat stream as a queue of {is_left, sample}; occupancy is the
//   number of pairs whose right beat has not yet gone out. Honours the
//   CIC_UP32_FEEDER_ATT_EN macro the same way the design build does.

module tb_cic_up32_feeder;

   localparam int WIDTH = 16;
   localparam int DEPTH = 4;

   logic             clk;
   logic             reset;
   logic [WIDTH-1:0] snd_l;
   logic [WIDTH-1:0] snd_r;
   logic             snd_strobe;
   logic [2:0]       att;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_startofpacket;
   logic             out_endofpacket;
   logic [1:0]       out_error;
   logic [2:0]       level;
   logic             overflow;
   logic             overflow_clr;

   cic_up32_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk               (clk),
      .reset             (reset),
      .snd_l             (snd_l),
      .snd_r             (snd_r),
      .snd_strobe        (snd_strobe),
      .att               (att),
      .out_data          (out_data),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_startofpacket (out_startofpacket),
      .out_endofpacket   (out_endofpacket),
      .out_error         (out_error),
      .level             (level),
      .overflow          (overflow),
      .overflow_clr      (overflow_clr)
   );

   // Clock and watchdog.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   // Scoreboard state.
   logic [WIDTH:0]   exp_q [$];
   logic             ovf_m;
   logic             hold_chk;
   logic [WIDTH+1:0] held;
   int               n_cmp;
   int               n_err;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [WIDTH-1:0] atten(input logic [WIDTH-1:0] s, input logic [2:0] a);
      int v;
      v = int'($signed(s));
`ifdef CIC_UP32_FEEDER_ATT_EN
      v = v >>> a;
`else
      v = v + 0 * int'(a);
`endif
      return v[WIDTH-1:0];
   endfunction

   function automatic int pairs_m();
      return (exp_q.size() + 1) / 2;
   endfunction

   // One clock cycle: drive inputs after a falling edge, score any beat that
   // transfers on the next rising edge, then check registered state after it.
   task automatic step(input logic stb, input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r,
                       input logic [2:0] a, input logic rdy, input logic clr);
      int             pb;
      int             pa;
      logic           vnow;
      logic           eop_xfer;
      logic           exp_nv;
      logic [WIDTH:0] beat;
      snd_strobe   = stb;
      snd_l        = l;
      snd_r        = r;
      att          = a;
      out_ready    = rdy;
      overflow_clr = clr;
      #1;
      vnow     = out_valid;
      eop_xfer = 1'b0;
      if (hold_chk) begin
         check_eq("stall_valid", out_valid, 1);
         check_eq("stall_hold", {out_startofpacket, out_endofpacket, out_data}, held);
      end
      pb = pairs_m();
      if (out_valid && out_ready) begin
         check_eq("beat_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            beat = exp_q.pop_front();
            check_eq("beat_data", out_data, beat[WIDTH-1:0]);
            check_eq("beat_sop", out_startofpacket, beat[WIDTH]);
            check_eq("beat_eop", out_endofpacket, !beat[WIDTH]);
            eop_xfer = !beat[WIDTH];
         end
      end
      if (stb) begin
         if (pb < DEPTH || eop_xfer) begin
            exp_q.push_back({1'b1, atten(l, a)});
            exp_q.push_back({1'b0, atten(r, a)});
         end else begin
            ovf_m = 1'b1;
         end
      end
      if (clr && !(stb && pb >= DEPTH && !eop_xfer)) ovf_m = 1'b0;
      pa       = pairs_m();
      exp_nv   = vnow ? (pa > 0) : (pb > 0);
      hold_chk = out_valid & !out_ready;
      held     = {out_startofpacket, out_endofpacket, out_data};
      @(posedge clk);
      @(negedge clk);
      check_eq("level", level, pa);
      check_eq("overflow", overflow, ovf_m);
      check_eq("valid_seq", out_valid, exp_nv);
      check_eq("out_error", out_error, 0);
   endtask

   task automatic idle(input logic rdy);
      step(1'b0, '0, '0, 3'd0, rdy, 1'b0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 200) begin
         idle(1'b1);
         n++;
      end
      check_eq("drain_empty", exp_q.size(), 0);
      check_eq("drain_idle", out_valid, 0);
   endtask

   task automatic check_reset_values();
      check_eq("rst_valid", out_valid, 0);
      check_eq("rst_data", out_data, 0);
      check_eq("rst_sop", out_startofpacket, 0);
      check_eq("rst_eop", out_endofpacket, 0);
      check_eq("rst_level", level, 0);
      check_eq("rst_overflow", overflow, 0);
   endtask

   initial begin
      n_cmp        = 0;
      n_err        = 0;
      ovf_m        = 1'b0;
      hold_chk     = 1'b0;
      held         = '0;
      reset        = 1'b1;
      snd_l        = '0;
      snd_r        = '0;
      snd_strobe   = 1'b0;
      att          = '0;
      out_ready    = 1'b0;
      overflow_clr = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values();
      reset = 1'b0;
      @(negedge clk);

      // Single pair with ready high: left at N+2, right at N+3.
      step(1'b1, 16'h1234, 16'hABCD, 3'd0, 1'b1, 1'b0);
      check_eq("t1_level_n", level, 1);
      check_eq("t1_valid_n", out_valid, 0);
      idle(1'b1);
      check_eq("t1_sop_beat", {out_valid, out_startofpacket, out_data}, {2'b11, atten(16'h1234, 3'd0)});
      idle(1'b1);
      check_eq("t1_eop_beat", {out_valid, out_endofpacket, out_data}, {2'b11, atten(16'hABCD, 3'd0)});
      idle(1'b1);
      check_eq("t1_level_end", level, 0);
      drain();

      // Stall on the left beat for 10 cycles, then release.
      step(1'b1, 16'h0F0F, 16'hF0F0, 3'd0, 1'b0, 1'b0);
      repeat (11) idle(1'b0);
      drain();

      // Five strobes into a 4-deep FIFO with the sink stalled.
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 16'(16'h1000 + i), 16'(16'h2000 + i), 3'd0, 1'b0, 1'b0);
      end
      check_eq("ovf_level", level, 4);
      check_eq("ovf_flag", overflow, 1);
      drain();
      step(1'b0, '0, '0, 3'd0, 1'b0, 1'b1);
      check_eq("ovf_cleared", overflow, 0);

      // Full FIFO, strobe coincident with the right-beat transfer.
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 16'(16'h3000 + i), 16'(16'h4000 + i), 3'd0, 1'b0, 1'b0);
      end
      idle(1'b1);
      step(1'b1, 16'h5555, 16'h6666, 3'd0, 1'b1, 1'b0);
      check_eq("coinc_level", level, 4);
      check_eq("coinc_ovf", overflow, 0);
      drain();

      // Reset while in the right beat of a packet.
      step(1'b1, 16'h7777, 16'h8888, 3'd0, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b1);
      check_eq("mid_eop", out_endofpacket, 1);
      reset = 1'b1;
      #1;
      check_reset_values();
      exp_q.delete();
      ovf_m    = 1'b0;
      hold_chk = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      step(1'b1, 16'h0001, 16'h0002, 3'd0, 1'b1, 1'b0);
      idle(1'b1);
      check_eq("post_rst_sop", {out_startofpacket, out_data}, {1'b1, 16'h0001});
      drain();

      // Attenuation on a negative full-scale and a positive sample.
      step(1'b1, 16'h8000, 16'h0100, 3'd2, 1'b1, 1'b0);
      drain();

      // Randomized traffic: balanced phase, then a congested phase.
      for (int i = 0; i < 500; i++) begin
         step($urandom_range(0, 2) == 0, 16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)),
              $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      end
      for (int i = 0; i < 300; i++) begin
         step($urandom_range(0, 1) == 0, 16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)),
              $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cic_up32_feeder.md
# cic_up32_feeder

Upstream framing stage for the ×32 CIC interpolator. Captures stereo PCM pairs presented with a one-cycle sample strobe from the sound-source mixer and buffers them in a small pair FIFO. Emits each pair as a two-beat Avalon-ST packet: left on the start-of-packet beat, right on the end-of-packet beat. Absorbs the interpolator's `in_ready` backpressure while it produces its 32 output samples per input.

## Interface
Parameters:
- `WIDTH`, 16: sample width in bits, two's complement.
- `DEPTH`, 4: FIFO capacity in stereo pairs; power of two, ≥2.

Ports:
- `clk`, in, 1: single clock; all logic rising-edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `snd_l`, in, WIDTH: left sample, valid on `snd_strobe`.
- `snd_r`, in, WIDTH: right sample, valid on `snd_strobe`.
- `snd_strobe`, in, 1: one-cycle pulse; writes the pair.
- `att`, in, 3: pre-attenuation shift (see Configuration).
- `out_data`, out, WIDTH: sample to interpolator `in_data`.
- `out_valid`, out, 1: to interpolator `in_valid`.
- `out_ready`, in, 1: from interpolator `in_ready`.
- `out_startofpacket`, out, 1: high on left beat.
- `out_endofpacket`, out, 1: high on right beat.
- `out_error`, out, 2: constant 2'b00.
- `level`, out, log2(DEPTH)+1: pairs held, including the pair in flight.
- `overflow`, out, 1: sticky; strobe arrived while full.
- `overflow_clr`, in, 1: synchronous clear of `overflow`.

## Operation
- Storage: two-port register FIFO of {L,R} pairs, with write pointer, read pointer and count.
- A pair is removed only when its right beat transfers.
- Output FSM states:
  - IDLE: `out_valid`=0. When count>0, load the head left sample, go to SEND_L.
  - SEND_L: `out_valid`=1, `out_startofpacket`=1. On `out_valid&out_ready`, load the head right sample, go to SEND_R.
  - SEND_R: `out_valid`=1, `out_endofpacket`=1. On transfer, pop the pair. Go to SEND_L (loading the next left) if count after pop >0, else IDLE.
- Avalon-ST readyLatency 0; transfer = `out_valid & out_ready`.
- `out_data`, SOP and EOP are registered and held stable while `out_valid & !out_ready`.
- Write: `snd_strobe` with count<DEPTH pushes the pair.
- Strobe with count==DEPTH:
  - If the SEND_R transfer completes in the same cycle, push succeeds (count unchanged).
  - Otherwise the new pair is dropped, `overflow` is set, and FIFO contents are unchanged.
- `overflow_clr` and an overflow event in the same cycle: `overflow` ends at 1.
- `level` = count, registered; updates the cycle after push or pop. A simultaneous push and pop leaves it unchanged.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_startofpacket`=0, `out_endofpacket`=0, `level`=0, `overflow`=0, FSM=IDLE, pointers=0.
- Latency: strobe at edge N (FIFO empty, IDLE) → `level`=1 and count=1 after edge N. The FSM loads the left sample at edge N+1, so `out_valid` and left data are visible after edge N+1.
- With `out_ready` held high: left transfers at edge N+2, right at edge N+3. If more pairs are queued, the next left appears after edge N+3 with no idle cycle.
- Reset asserted mid-packet: FIFO is flushed and the partial packet is abandoned. After release, the first beat is always a left/SOP beat.
- Pointers wrap modulo DEPTH; count is saturating-checked, never wraps.

## Configuration
- Macro `CIC_UP32_FEEDER_ATT_EN`.
- Defined: each sample is arithmetic-shifted right by `att` (0–7, sign-extended) at push time, giving headroom against CIC gain. `att` is sampled on the strobe cycle.
- Undefined: samples are stored unmodified and `att` is ignored. The port remains for a stable interface.

## Test plan
- Reset, then one strobe L=16'h1234, R=16'hABCD with `out_ready`=1 → beats 1234/SOP then ABCD/EOP at edges N+2 and N+3; `level` goes 1→0; `out_error`=00.
- Hold `out_ready`=0 for 10 cycles during SEND_L → `out_data`=L and SOP stay stable. Release → L transfers, then R.
- 5 strobes with `out_ready`=0, DEPTH=4 → `level`=4, `overflow`=1, 5th pair absent. Drain → exactly 4 packets in order. Pulse `overflow_clr` → 0.
- Full FIFO, strobe coincident with an SEND_R transfer → no overflow, `level` stays 4, new pair emitted last.
- Assert `reset` during SEND_R → outputs return to reset values. Next strobe pair L=1,R=2 emits with SOP on 1.
- With `CIC_UP32_FEEDER_ATT_EN` and `att`=2, L=16'h8000, R=16'h0100 → beats 16'hE000, 16'h0040. Without the macro → 16'h8000, 16'h0100.
